// File: rtl/bin2bcd_pkg.sv
// Shared double-dabble helpers and elaboration-time sizing functions for bin2bcd_pipe.
package bin2bcd_pkg;

  localparam int MAX_DIG  = 10;   // a 32-bit magnitude never needs more than ten digits
  localparam int BCD_MAXW = 4 * MAX_DIG;

  typedef logic [BCD_MAXW-1:0] bcd_vec_t;

  function automatic logic [3:0] add3_digit(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  function automatic bcd_vec_t dd_step(input bcd_vec_t bcd, input logic bit_in);
    bcd_vec_t adj;
    for (int i = 0; i < MAX_DIG; i++) begin
      adj[4*i +: 4] = add3_digit(bcd[4*i +: 4]);
    end
    return (adj << 1) | bcd_vec_t'(bit_in);
  endfunction

  function automatic int nstg(input int dw, input int bps);
    return (dw + bps - 1) / bps;
  endfunction

  function automatic int min_ndig(input int dw, input int signed_en);
    longint unsigned mag;
    longint unsigned p;
    int              n;
    mag = (signed_en != 0) ? (64'd1 << (dw - 1)) : ((64'd1 << dw) - 64'd1);
    n   = 1;
    p   = 64'd10;
    for (int i = 0; i < 20; i++) begin
      if (p <= mag) begin
        n = n + 1;
        p = p * 64'd10;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bin2bcd_if.sv
// Handshake bundle between a binary producer and the bin2bcd_pipe converter.
// out_ndig exists only when BIN2BCD_LZ_EN is defined.
interface bin2bcd_if #(
  parameter int DW   = 11,
  parameter int NDIG = 4
);
  logic [DW-1:0]     in_data;
  logic              in_vld;
  logic              in_rdy;
  logic [4*NDIG-1:0] out_bcd;
  logic              out_sign;
  logic              out_vld;
  logic              out_rdy;
`ifdef BIN2BCD_LZ_EN
  logic [$clog2(NDIG+1)-1:0] out_ndig;

  modport master (output in_data, in_vld, out_rdy,
                  input  in_rdy, out_bcd, out_sign, out_vld, out_ndig);
  modport slave  (input  in_data, in_vld, out_rdy,
                  output in_rdy, out_bcd, out_sign, out_vld, out_ndig);
`else
  modport master (output in_data, in_vld, out_rdy,
                  input  in_rdy, out_bcd, out_sign, out_vld);
  modport slave  (input  in_data, in_vld, out_rdy,
                  output in_rdy, out_bcd, out_sign, out_vld);
`endif
endinterface

// File: rtl/bin2bcd_pipe_stage.sv
// One double-dabble pipeline slot: ITERS add-3/shift iterations feeding a register set.
module bin2bcd_stage
  import bin2bcd_pkg::*;
#(
  parameter int DW    = 11,
  parameter int NDIG  = 4,
  parameter int ITERS = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              src_vld,
  input  logic              src_sign,
  input  logic [DW-1:0]     src_mag,
  input  logic [4*NDIG-1:0] src_bcd,
  output logic              vld_reg,
  output logic              sign_reg,
  output logic [DW-1:0]     mag_reg,
  output logic [4*NDIG-1:0] bcd_reg
);

  bcd_vec_t      bcd_work;
  logic [DW-1:0] mag_work;
  logic          unused_bcd_hi;

  always_comb begin
    bcd_work = bcd_vec_t'(src_bcd);
    mag_work = src_mag;
    for (int i = 0; i < ITERS; i++) begin
      bcd_work = dd_step(bcd_work, mag_work[DW-1]);
      mag_work = mag_work << 1;
    end
  end

  // Digits above NDIG stay zero: the top refuses an NDIG too small for the worst magnitude.
  assign unused_bcd_hi = |(bcd_work >> (4*NDIG));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_reg  <= 1'b0;
      sign_reg <= 1'b0;
      mag_reg  <= '0;
      bcd_reg  <= '0;
    end else if (en) begin
      vld_reg  <= src_vld;
      sign_reg <= src_sign;
      mag_reg  <= mag_work;
      bcd_reg  <= bcd_work[4*NDIG-1:0];
    end
  end

endmodule

// File: rtl/bin2bcd_pipe.sv
// Fully pipelined signed/unsigned binary to BCD converter with valid/ready on both sides.
// Optional BIN2BCD_LZ_EN adds out_ndig (significant digit count) on the interface.
module bin2bcd_pipe
  import bin2bcd_pkg::*;
#(
  parameter int DW     = 11,
  parameter int SIGNED = 1,
  parameter int NDIG   = 4,
  parameter int BPS    = 2
) (
  input logic      clk,
  input logic      rstn,
  bin2bcd_if.slave bus
);

  localparam int NSTG = nstg(DW, BPS);

  if (DW < 2 || DW > 32) begin : g_bad_dw
    $error("bin2bcd_pipe: DW must be within 2..32");
  end
  if (BPS < 1 || BPS > DW) begin : g_bad_bps
    $error("bin2bcd_pipe: BPS must be within 1..DW");
  end
  if (NDIG < min_ndig(DW, SIGNED) || NDIG > MAX_DIG) begin : g_bad_ndig
    $error("bin2bcd_pipe: NDIG cannot hold the largest magnitude");
  end

  logic              stall;
  logic              sign_next;
  logic [DW-1:0]     mag_next;
  logic              vld0_reg;
  logic              sign0_reg;
  logic [DW-1:0]     mag0_reg;
  logic              out_vld_reg;
  logic              out_sign_reg;
  logic [4*NDIG-1:0] out_bcd_reg;
  logic              unused_mag_tail;

  logic              vld_pipe  [NSTG+1];
  logic              sign_pipe [NSTG+1];
  logic [DW-1:0]     mag_pipe  [NSTG+1];
  logic [4*NDIG-1:0] bcd_pipe  [NSTG+1];

  // Whole-pipe stall: no bubble collapsing, every slot holds together.
  assign stall      = out_vld_reg & ~bus.out_rdy;
  assign bus.in_rdy = ~stall;

  // Negating at DW bits maps the most negative input to 2^(DW-1) without wrapping.
  always_comb begin
    sign_next = (SIGNED != 0) && bus.in_data[DW-1];
    mag_next  = sign_next ? ~bus.in_data + DW'(1) : bus.in_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld0_reg  <= 1'b0;
      sign0_reg <= 1'b0;
      mag0_reg  <= '0;
    end else if (!stall) begin
      vld0_reg <= bus.in_vld;
      if (bus.in_vld) begin
        sign0_reg <= sign_next;
        mag0_reg  <= mag_next;
      end
    end
  end

  assign vld_pipe[0]  = vld0_reg;
  assign sign_pipe[0] = sign0_reg;
  assign mag_pipe[0]  = mag0_reg;
  assign bcd_pipe[0]  = '0;

  for (genvar gi = 1; gi <= NSTG; gi++) begin : g_stage
    localparam int ITERS = (gi == NSTG) ? DW - (NSTG - 1) * BPS : BPS;
    bin2bcd_stage #(
      .DW    (DW),
      .NDIG  (NDIG),
      .ITERS (ITERS)
    ) u_stage (
      .clk      (clk),
      .rstn     (rstn),
      .en       (~stall),
      .src_vld  (vld_pipe[gi-1]),
      .src_sign (sign_pipe[gi-1]),
      .src_mag  (mag_pipe[gi-1]),
      .src_bcd  (bcd_pipe[gi-1]),
      .vld_reg  (vld_pipe[gi]),
      .sign_reg (sign_pipe[gi]),
      .mag_reg  (mag_pipe[gi]),
      .bcd_reg  (bcd_pipe[gi])
    );
  end

  // Every magnitude bit has been shifted out by the last stage.
  assign unused_mag_tail = |mag_pipe[NSTG];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_vld_reg  <= 1'b0;
      out_sign_reg <= 1'b0;
      out_bcd_reg  <= '0;
    end else if (!stall) begin
      out_vld_reg  <= vld_pipe[NSTG];
      out_sign_reg <= sign_pipe[NSTG];
      out_bcd_reg  <= bcd_pipe[NSTG];
    end
  end

  assign bus.out_vld  = out_vld_reg;
  assign bus.out_sign = out_vld_reg & out_sign_reg;
  assign bus.out_bcd  = out_vld_reg ? out_bcd_reg : '0;

`ifdef BIN2BCD_LZ_EN
  localparam int NW = $clog2(NDIG + 1);
  logic [NW-1:0] ndig_cnt;

  always_comb begin
    ndig_cnt = NW'(1);
    for (int i = 1; i < NDIG; i++) begin
      if (out_bcd_reg[4*i +: 4] != 4'd0) ndig_cnt = NW'(i + 1);
    end
  end

  assign bus.out_ndig = out_vld_reg ? ndig_cnt : '0;
`endif

endmodule

// File: tb/tb_bin2bcd_pipe.sv
// Directed bench for bin2bcd_pipe: default, unsigned 16-bit, BPS=1 and BPS=DW builds side by side.
module tb_bin2bcd_pipe;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bin2bcd_if #(.DW(11), .NDIG(4)) bus_d  ();
  bin2bcd_if #(.DW(16), .NDIG(5)) bus_u  ();
  bin2bcd_if #(.DW(11), .NDIG(4)) bus_b1 ();
  bin2bcd_if #(.DW(11), .NDIG(4)) bus_bw ();

  bin2bcd_pipe #(.DW(11), .SIGNED(1), .NDIG(4), .BPS(2))  u_dut_d  (.clk(clk), .rstn(rstn), .bus(bus_d));
  bin2bcd_pipe #(.DW(16), .SIGNED(0), .NDIG(5), .BPS(2))  u_dut_u  (.clk(clk), .rstn(rstn), .bus(bus_u));
  bin2bcd_pipe #(.DW(11), .SIGNED(1), .NDIG(4), .BPS(1))  u_dut_b1 (.clk(clk), .rstn(rstn), .bus(bus_b1));
  bin2bcd_pipe #(.DW(11), .SIGNED(1), .NDIG(4), .BPS(11)) u_dut_bw (.clk(clk), .rstn(rstn), .bus(bus_bw));

  // Reference conversion by repeated division, independent of double-dabble.
  function automatic logic [16:0] model11(input logic [10:0] v);
    int          mag;
    logic        s;
    logic [15:0] b;
    s   = v[10];
    mag = s ? 2048 - int'(v) : int'(v);
    for (int i = 0; i < 4; i++) begin
      b[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    return {s, b};
  endfunction

  task automatic test_reset();
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (bus_d.out_vld !== 1'b0 || bus_d.out_bcd !== 16'h0 || bus_d.out_sign !== 1'b0) begin
      failures++;
      $display("FAIL reset_async_outputs vld=%b bcd=%h sign=%b expected 0/0000/0",
               bus_d.out_vld, bus_d.out_bcd, bus_d.out_sign);
    end
    checks++;
    if (bus_d.in_rdy !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_rdy got=%b expected 1", bus_d.in_rdy);
    end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_d.out_vld, bus_u.out_vld, bus_b1.out_vld, bus_bw.out_vld} !== 4'b0000 ||
        {bus_d.in_rdy, bus_u.in_rdy, bus_b1.in_rdy, bus_bw.in_rdy} !== 4'b1111) begin
      failures++;
      $display("FAIL reset_release vld=%b%b%b%b rdy=%b%b%b%b expected 0000/1111",
               bus_d.out_vld, bus_u.out_vld, bus_b1.out_vld, bus_bw.out_vld,
               bus_d.in_rdy, bus_u.in_rdy, bus_b1.in_rdy, bus_bw.in_rdy);
    end
  endtask

  task automatic test_latency();
    int lat = 0;
    @(negedge clk);
    bus_d.in_data = 11'h400;
    bus_d.in_vld  = 1'b1;
    @(negedge clk);
    bus_d.in_vld  = 1'b0;
    bus_d.in_data = 11'h155;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      if (bus_d.out_vld === 1'b1) lat = c;
      else begin
        checks++;
        if (bus_d.out_bcd !== 16'h0 || bus_d.out_sign !== 1'b0) begin
          failures++;
          $display("FAIL idle_forced_zero cycle=%0d bcd=%h sign=%b expected 0000/0",
                   c, bus_d.out_bcd, bus_d.out_sign);
        end
      end
    end
    $display("xfer latency in=0x400 bcd=%h sign=%b after %0d cycles", bus_d.out_bcd, bus_d.out_sign, lat);
    checks++;
    if (lat !== 7) begin
      failures++;
      $display("FAIL latency_default got=%0d expected 7", lat);
    end
    checks++;
    if (bus_d.out_bcd !== 16'h1024 || bus_d.out_sign !== 1'b1) begin
      failures++;
      $display("FAIL most_negative bcd=%h sign=%b expected 1024/1", bus_d.out_bcd, bus_d.out_sign);
    end
`ifdef BIN2BCD_LZ_EN
    checks++;
    if (bus_d.out_ndig !== 3'd4) begin
      failures++;
      $display("FAIL ndig_most_negative got=%0d expected 4", bus_d.out_ndig);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [10:0] vin [3];
    logic [15:0] eb  [3];
    logic        es  [3];
    int          en  [3];
    vin = '{11'h3FF, 11'h7FF, 11'h000};
    eb  = '{16'h1023, 16'h0001, 16'h0000};
    es  = '{1'b0, 1'b1, 1'b0};
    en  = '{4, 1, 1};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus_d.in_vld  = 1'b1;
      bus_d.in_data = vin[k];
    end
    @(negedge clk);
    bus_d.in_vld = 1'b0;
    for (int c = 0; c < 20 && bus_d.out_vld !== 1'b1; c++) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      $display("xfer b2b in=%h bcd=%h sign=%b", vin[k], bus_d.out_bcd, bus_d.out_sign);
      checks++;
      if (bus_d.out_vld !== 1'b1 || bus_d.out_bcd !== eb[k] || bus_d.out_sign !== es[k]) begin
        failures++;
        $display("FAIL b2b_%0d vld=%b bcd=%h sign=%b expected 1/%h/%b",
                 k, bus_d.out_vld, bus_d.out_bcd, bus_d.out_sign, eb[k], es[k]);
      end
`ifdef BIN2BCD_LZ_EN
      checks++;
      if (int'(bus_d.out_ndig) != en[k]) begin
        failures++;
        $display("FAIL b2b_ndig_%0d got=%0d expected %0d", k, bus_d.out_ndig, en[k]);
      end
`endif
      @(negedge clk);
    end
    checks++;
    if (bus_d.out_vld !== 1'b0 || bus_d.out_bcd !== 16'h0) begin
      failures++;
      $display("FAIL b2b_drain vld=%b bcd=%h expected 0/0000", bus_d.out_vld, bus_d.out_bcd);
    end
  endtask

  task automatic test_stall_stream();
    logic [16:0] exp_q [$];
    logic [10:0] pend;
    logic        stall_win;
    int          sent = 0;
    int          got  = 0;
    int          cyc  = 0;
    pend = 11'($urandom);
    while (got < 20 && cyc < 200) begin
      @(negedge clk);
      stall_win     = (cyc >= 12 && cyc < 17);
      bus_d.out_rdy = ~stall_win;
      bus_d.in_vld  = (sent < 20);
      bus_d.in_data = pend;
      #1;
      checks++;
      if (bus_d.in_rdy !== ~stall_win) begin
        failures++;
        $display("FAIL stall_in_rdy cycle=%0d got=%b expected %b", cyc, bus_d.in_rdy, ~stall_win);
      end
      if (stall_win) begin
        checks++;
        if (bus_d.out_vld !== 1'b1) begin
          failures++;
          $display("FAIL stall_out_vld cycle=%0d got=%b expected 1", cyc, bus_d.out_vld);
        end
      end
      if (bus_d.in_vld && bus_d.in_rdy) begin
        exp_q.push_back(model11(pend));
        sent++;
        pend = 11'($urandom);
      end
      if (bus_d.out_vld === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL stream_extra cycle=%0d bcd=%h sign=%b expected no output",
                   cyc, bus_d.out_bcd, bus_d.out_sign);
        end else begin
          if ({bus_d.out_sign, bus_d.out_bcd} !== exp_q[0]) begin
            failures++;
            $display("FAIL stream_data cycle=%0d got=%b/%h expected %b/%h",
                     cyc, bus_d.out_sign, bus_d.out_bcd, exp_q[0][16], exp_q[0][15:0]);
          end
          if (bus_d.out_rdy) begin
            $display("xfer stream #%0d bcd=%h sign=%b", got, bus_d.out_bcd, bus_d.out_sign);
            void'(exp_q.pop_front());
            got++;
          end
        end
      end
      cyc++;
    end
    checks++;
    if (got != 20 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL stream_count got=%0d pending=%0d expected 20/0", got, exp_q.size());
    end
    bus_d.in_vld  = 1'b0;
    bus_d.out_rdy = 1'b1;
  endtask

  task automatic test_reset_inflight();
    int seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus_d.in_vld  = 1'b1;
      bus_d.in_data = 11'(16 + k);
    end
    @(negedge clk);
    bus_d.in_vld = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (bus_d.out_vld !== 1'b0 || bus_d.out_bcd !== 16'h0) begin
        failures++;
        $display("FAIL reset_flush cycle=%0d vld=%b bcd=%h expected 0/0000", c, bus_d.out_vld, bus_d.out_bcd);
      end
    end
    bus_d.in_vld  = 1'b1;
    bus_d.in_data = 11'h005;
    @(negedge clk);
    bus_d.in_vld = 1'b0;
    for (int c = 1; c <= 20 && seen == 0; c++) begin
      @(negedge clk);
      if (bus_d.out_vld === 1'b1) seen = c;
    end
    $display("xfer after_reset bcd=%h sign=%b after %0d cycles", bus_d.out_bcd, bus_d.out_sign, seen);
    checks++;
    if (seen != 7 || bus_d.out_bcd !== 16'h0005 || bus_d.out_sign !== 1'b0) begin
      failures++;
      $display("FAIL after_reset lat=%0d bcd=%h sign=%b expected 7/0005/0", seen, bus_d.out_bcd, bus_d.out_sign);
    end
  endtask

  task automatic test_unsigned();
    logic [15:0] vin [3];
    logic [19:0] eb  [3];
    int          en  [3];
    int          lat;
    vin = '{16'hFFFF, 16'h0007, 16'h8000};
    eb  = '{20'h65535, 20'h00007, 20'h32768};
    en  = '{5, 1, 5};
    for (int k = 0; k < 3; k++) begin
      lat = 0;
      @(negedge clk);
      bus_u.in_vld  = 1'b1;
      bus_u.in_data = vin[k];
      @(negedge clk);
      bus_u.in_vld = 1'b0;
      for (int c = 1; c <= 20 && lat == 0; c++) begin
        @(negedge clk);
        if (bus_u.out_vld === 1'b1) lat = c;
      end
      $display("xfer unsigned in=%h bcd=%h sign=%b after %0d cycles", vin[k], bus_u.out_bcd, bus_u.out_sign, lat);
      checks++;
      if (lat != 9 || bus_u.out_bcd !== eb[k] || bus_u.out_sign !== 1'b0) begin
        failures++;
        $display("FAIL unsigned_%0d lat=%0d bcd=%h sign=%b expected 9/%h/0",
                 k, lat, bus_u.out_bcd, bus_u.out_sign, eb[k]);
      end
`ifdef BIN2BCD_LZ_EN
      checks++;
      if (int'(bus_u.out_ndig) != en[k]) begin
        failures++;
        $display("FAIL unsigned_ndig_%0d got=%0d expected %0d", k, bus_u.out_ndig, en[k]);
      end
`endif
    end
  endtask

  task automatic test_bps_variants();
    logic [10:0] vin [3];
    logic [15:0] eb  [3];
    logic        es  [3];
    int          lat1;
    int          latw;
    vin = '{11'h400, 11'h2A5, 11'h7FF};
    eb  = '{16'h1024, 16'h0677, 16'h0001};
    es  = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      lat1 = 0;
      latw = 0;
      @(negedge clk);
      bus_b1.in_vld  = 1'b1;
      bus_b1.in_data = vin[k];
      bus_bw.in_vld  = 1'b1;
      bus_bw.in_data = vin[k];
      @(negedge clk);
      bus_b1.in_vld = 1'b0;
      bus_bw.in_vld = 1'b0;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (lat1 == 0 && bus_b1.out_vld === 1'b1) begin
          lat1 = c;
          $display("xfer bps1 in=%h bcd=%h sign=%b", vin[k], bus_b1.out_bcd, bus_b1.out_sign);
          checks++;
          if (bus_b1.out_bcd !== eb[k] || bus_b1.out_sign !== es[k]) begin
            failures++;
            $display("FAIL bps1_data_%0d bcd=%h sign=%b expected %h/%b", k, bus_b1.out_bcd, bus_b1.out_sign, eb[k], es[k]);
          end
        end
        if (latw == 0 && bus_bw.out_vld === 1'b1) begin
          latw = c;
          $display("xfer bpsdw in=%h bcd=%h sign=%b", vin[k], bus_bw.out_bcd, bus_bw.out_sign);
          checks++;
          if (bus_bw.out_bcd !== eb[k] || bus_bw.out_sign !== es[k]) begin
            failures++;
            $display("FAIL bpsdw_data_%0d bcd=%h sign=%b expected %h/%b", k, bus_bw.out_bcd, bus_bw.out_sign, eb[k], es[k]);
          end
        end
      end
      checks++;
      if (lat1 != 12 || latw != 2) begin
        failures++;
        $display("FAIL bps_latency_%0d bps1=%0d bpsdw=%0d expected 12/2", k, lat1, latw);
      end
    end
  endtask

  initial begin
    bus_d.in_vld  = 1'b0; bus_d.in_data  = '0; bus_d.out_rdy  = 1'b1;
    bus_u.in_vld  = 1'b0; bus_u.in_data  = '0; bus_u.out_rdy  = 1'b1;
    bus_b1.in_vld = 1'b0; bus_b1.in_data = '0; bus_b1.out_rdy = 1'b1;
    bus_bw.in_vld = 1'b0; bus_bw.in_data = '0; bus_bw.out_rdy = 1'b1;
    test_reset();
    test_latency();
    test_back_to_back();
    test_stall_stream();
    test_reset_inflight();
    test_unsigned();
    test_bps_variants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
